lut_mul_seq_ctrl: RTL and testbench

//  Sequencer for the 32x4 LUT multiplier datapath: accepts a 32x32 unsigned multiply request and

---
 rtl/lut_mul_pkg.sv | 16 +
 rtl/lut_mul_tag_pipe.sv | 39 +++
 rtl/lut_mul_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_lut_mul_seq_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lut_mul_pkg.sv
// Shared types and widths for the LUT multiplier sequencer.
package lut_mul_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int NIB_W  = 4;   // multiplier narrow operand width
  localparam int PP_W   = 36;  // significant partial product bits
  localparam int PROD_W = 64;  // full product width

  // True when every nibble above index k is zero, i.e. issuing nibble k
  // already covers all non-zero digits of b.
  function automatic logic hi_nibs_zero(input logic [63:0] b, input int k);
    return (b >> (NIB_W * (k + 1))) == 64'd0;
  endfunction

endpackage

// File: rtl/lut_mul_tag_pipe.sv
// Delay line carrying {valid, nibble index} of each issued nibble so the
// returning partial product knows its shift amount.
module lut_mul_tag_pipe
  import lut_mul_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int KW     = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_vld,
  input  logic [KW-1:0] in_k,
  output logic          out_vld,
  output logic [KW-1:0] out_k
);

  logic [STAGES:1]         vld_pipe;
  logic [STAGES:1][KW-1:0] k_pipe;

  // Shift tags one stage per cycle; cleared on reset so no stale return
  // survives an aborted operation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      k_pipe   <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      k_pipe[1]   <= in_k;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        k_pipe[i]   <= k_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[STAGES];
  assign out_k   = k_pipe[STAGES];

endmodule

// File: rtl/lut_mul_seq_ctrl.sv
// Sequencer for a 32x4 LUT multiplier: slices B into nibbles, issues one
// per cycle, accumulates shifted partial products, returns the 64b product.
// Build option LUT_MUL_EARLY_TERM_EN: stop issuing once the remaining
// higher nibbles of B are all zero.
module lut_mul_seq_ctrl
  import lut_mul_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int A_W     = 32,
  parameter int NIB     = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [A_W-1:0]      in_a,
  input  logic [NIB_W*NIB-1:0] in_b,
  output logic [A_W-1:0]      mul_a,
  output logic [NIB_W-1:0]    mul_b,
  input  logic [PROD_W-1:0]   mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   out_prod,
  output logic                busy
);

  localparam int B_W = NIB_W * NIB;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW  = $clog2(NIB + 1);

  state_t            state, state_nxt;
  logic [B_W-1:0]    b_q;
  logic [KW-1:0]     k_q, k_nxt;
  logic [CW-1:0]     iss_cnt, ret_cnt;
  logic [PROD_W-1:0] acc, pp;
  logic              accept, last_issue, drained;
  logic              tag_vld;
  logic [KW-1:0]     tag_k;
  logic              unused_hi;

  assign unused_hi = ^mul_result[PROD_W-1:PP_W];

  assign k_nxt   = k_q + KW'(1);
  assign drained = (ret_cnt == iss_cnt);
  assign pp      = PROD_W'(mul_result[PP_W-1:0]) << (NIB_W * int'(tag_k));

`ifdef LUT_MUL_EARLY_TERM_EN
  assign last_issue = (k_q == KW'(NIB - 1)) || hi_nibs_zero(64'(b_q), int'(k_q));
`else
  assign last_issue = (k_q == KW'(NIB - 1));
`endif

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and accept strobe.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE:  if (in_valid) begin
                 accept    = 1'b1;
                 state_nxt = S_ISSUE;
               end
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (drained)    state_nxt = S_DONE;
      S_DONE:  if (out_ready)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, nibble issue and issue counting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a   <= '0;
      mul_b   <= '0;
      b_q     <= '0;
      k_q     <= '0;
      iss_cnt <= '0;
    end else if (accept) begin
      mul_a   <= in_a;
      b_q     <= in_b;
      mul_b   <= in_b[NIB_W-1:0];
      k_q     <= '0;
      iss_cnt <= CW'(1);
    end else if (state == S_ISSUE) begin
      if (last_issue) begin
        mul_b <= '0;
      end else begin
        k_q     <= k_nxt;
        mul_b   <= b_q[NIB_W*k_nxt +: NIB_W];
        iss_cnt <= iss_cnt + CW'(1);
      end
    end
  end

  // Accumulate returning partial products; a new request clears the sum.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      ret_cnt <= '0;
    end else if (accept) begin
      acc     <= '0;
      ret_cnt <= '0;
    end else if (tag_vld) begin
      acc     <= acc + pp;
      ret_cnt <= ret_cnt + CW'(1);
    end
  end

  // Product register, loaded once all partial products have returned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          out_prod <= '0;
    else if (state == S_DRAIN && drained) out_prod <= acc;
  end

  lut_mul_tag_pipe #(.STAGES(MUL_LAT), .KW(KW)) u_tag_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .in_vld  (state == S_ISSUE),
    .in_k    (k_q),
    .out_vld (tag_vld),
    .out_k   (tag_k)
  );

endmodule

// File: tb/tb_lut_mul_seq_ctrl.sv
// Randomized self-checking bench for lut_mul_seq_ctrl with a one-cycle
// 32x4 multiplier model attached to the operand ports.
module tb_lut_mul_seq_ctrl;

  localparam int MUL_LAT = 1;
  localparam int NIB     = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, mul_a;
  logic [3:0]  mul_b;
  logic [63:0] mul_result, out_prod;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Multiplier: registers a*b once per clock.
  always_ff @(posedge clk) mul_result <= 64'(mul_a) * 64'(mul_b);

  lut_mul_seq_ctrl #(.MUL_LAT(MUL_LAT), .A_W(32), .NIB(NIB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Cycles from accept edge to out_valid: issues + return latency + 1.
  function automatic int exp_lat(input logic [31:0] b);
    int n;
`ifdef LUT_MUL_EARLY_TERM_EN
    n = 1;
    for (int k = 0; k < NIB; k++) if (((b >> (4 * k)) & 32'hF) != 0) n = k + 1;
`else
    n = NIB;
`endif
    return n + MUL_LAT + 1;
  endfunction

  // One full transaction from IDLE; caller sits on a negedge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit spurious);
    int cyc;
    bit bad;
    logic [63:0] exp;
    exp = 64'(a) * 64'(b);
    chk("idle_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b0;
    @(negedge clk);
    if (spurious) begin
      in_a = ~a; in_b = b ^ 32'h5A5A_A5A5;
    end else begin
      in_valid = 1'b0;
    end
    chk("mul_a", 64'(mul_a), 64'(a));
    cyc = 0; bad = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready || !busy) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(cyc), 64'(exp_lat(b)));
    chk("busy_no_rdy", 64'(bad), 64'd0);
    chk("prod", out_prod, exp);
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_prod !== exp) bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_vld", 64'(out_valid), 64'd0);
    chk("handoff_rdy", 64'(in_ready), 64'd1);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_prod", out_prod, 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(32'd85442222, 32'h0000_0003, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(32'd85442222, 32'h8000_0000, 5, 1'b0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b1);
    do_op(32'hCAFE_F00D, 32'h0101_0101, 0, 1'b0);
    do_op(32'hDEAD_BEEF, 32'h0000_0000, 0, 1'b0);
    do_op(32'hDEAD_BEEF, 32'h0000_0010, 0, 1'b0);

    // Asynchronous reset in the middle of issuing nibble 4.
    in_valid = 1'b1; in_a = 32'h7777_7777; in_b = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_b", 64'(mul_b), 64'd0);
    chk("arst_prod", out_prod, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_op(32'd2, 32'd8, 0, 1'b0);

    // Random operands with a random number of significant B nibbles.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> (4 * $urandom_range(0, 8));
      do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
